regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port between NREQ writeback sources.
//  Default sources: 0 = ALU result, 1 = load data, 2 = stack-pointer adjust.
//  Round-robin grant, one commit per cycle, only while the CPU state is writeback.
//  Keeps a per-register pending-write scoreboard so issue logic can stall on RAW/WAW hazards.
//  Sits between execute/memory stages and register_file (drives write_reg/write_en/write_data).
// PARAMETERS
//  NREQ   3   number of writeback requesters (2..8)
//  XLEN   64  data width
//  NREG   32  architectural registers; index width = $clog2(NREG)
// PORTS
//  clk           in   1          system clock, all state on rising edge
//  reset         in   1          synchronous, active-high
//  state         in   3          CPU phase; writeback when state == STATE_WB (3'b100)
//  req_valid     in   NREQ       requester i holds a result
//  req_ready     out  NREQ       requester i's result commits this cycle
//  req_reg       in   NREQx5     destination register per requester
//  req_data      in   NREQxXLEN  result per requester
//  issue_valid   in   1          decode claims destination issue_reg
//  issue_reg     in   5          register being claimed
//  issue_ready   out  1          claim accepted this cycle
//  rd_reg1..3    in   5 each     source registers of the instruction in decode
//  rd_hazard     out  3          bit k = rd_reg(k+1) has a pending write
//  write_reg     out  5          to register_file
//  write_en      out  1          to register_file
//  write_data    out  XLEN       to register_file
//  busy_mask     out  NREG       scoreboard state, bit r = write to r pending
//  err_unclaimed out  1          sticky: a commit hit a register whose busy bit was clear
// BEHAVIOUR
//  Reset (sync):
//   - clears busy_mask, err_unclaimed and rr_ptr (rr_ptr=0).
//   - While reset is high, req_ready=0, write_en=0 and issue_ready=0, overriding all other terms.
//  Arbitration, combinational in-cycle:
//   - When state==STATE_WB, the winner is the first i with req_valid[i], scanning from rr_ptr upward with wrap.
//   - req_ready is one-hot to the winner; req_ready=0 whenever state!=STATE_WB.
//   - write_en = |req_ready; write_reg/write_data come from the winner.
//   - write_reg=0 and write_data=0 when write_en=0.
//  Handshake:
//   - Commit = req_valid[i] && req_ready[i]; register_file captures on the same edge.
//   - Requesters hold valid/reg/data stable until ready; valid never drops without a commit.
//  rr_ptr:
//   - On a commit by i, rr_ptr <= (i+1) mod NREQ; otherwise it holds.
//   - Losers keep valid high and win in a later WB cycle.
//   - Starvation bound: NREQ WB cycles.
//  Scoreboard:
//   - issue_ready = issue_valid-independent ~busy_mask[issue_reg].
//   - An accepted claim sets busy[issue_reg] at the edge; a commit clears busy[write_reg] at the edge.
//   - Issue and commit on the same register in one cycle: issue_ready=0 (no bypass) and busy clears.
//   - Issue and commit on different registers in one cycle: both take effect.
//  Errors:
//   - A commit to a register with busy=0 still writes the register and sets err_unclaimed (cleared only by reset).
//   - The busy bit stays 0.
//  Register 0 and SP (r31) are ordinary entries: no special-casing.
//  rd_hazard[k] = busy_mask[rd_reg(k+1)], combinational; a commit in the same cycle is not bypassed.
// STRUCTURE
//  cpu_pkg: STATE_WB=3'b100, REG_SP=5'd31, XLEN, NREG, REG_IDX_W=5.
//  Sub-module rr_arbiter #(N) (req, ptr -> one-hot gnt, gnt_idx) holds the pure arbitration logic.
//  The scoreboard and rr_ptr registers live in the top-level module.
// TESTING
//  1. Reset, then state=WB, valid=3'b000: write_en=0, busy_mask=0, err_unclaimed=0.
//  2. Claim r5; ALU commit (r5, 64'hDEAD) in WB: write_en=1, write_reg=5, busy[5]: 1->0 the next cycle.
//  3. All three valid (r1,r2,r31), 3 WB cycles: grants 0,1,2 in order; SP data on cycle 3; rr_ptr wraps to 0.
//  4. Valid asserted while state=3'b011 for 4 cycles: req_ready=0 and write_en=0 throughout; commit on the first WB.
//  5. busy[7]=1, issue r7 during a commit to r7: issue_ready=0, busy[7]=0 after the edge, rd_hazard for r7 clears.
//  6. Commit to an unclaimed r9: write happens, err_unclaimed=1 sticky; reset mid-burst: all state clears on that edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants for the writeback path: phase encoding, register
// indexing and default datapath sizes.
package cpu_pkg;

   localparam logic [2:0] STATE_WB  = 3'b100;
   localparam int         REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_SP = 5'd31;
   localparam int         XLEN      = 64;
   localparam int         NREG      = 32;

   // Round-robin successor of a granted index, wrapping at n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin arbiter: the first asserted request at or
// after ptr (with wrap) wins; gnt is one-hot or zero.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   always_comb begin
      logic found;
      int   idx;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between NREQ writeback sources and
// tracks pending destination writes so decode can stall on RAW/WAW hazards.
module regfile_write_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int NREG = cpu_pkg::NREG
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [2:0]                           state,
   input  logic [NREQ-1:0]                      req_valid,
   output logic [NREQ-1:0]                      req_ready,
   input  logic [NREQ-1:0][cpu_pkg::REG_IDX_W-1:0] req_reg,
   input  logic [NREQ-1:0][XLEN-1:0]            req_data,
   input  logic                                 issue_valid,
   input  logic [cpu_pkg::REG_IDX_W-1:0]        issue_reg,
   output logic                                 issue_ready,
   input  logic [cpu_pkg::REG_IDX_W-1:0]        rd_reg1,
   input  logic [cpu_pkg::REG_IDX_W-1:0]        rd_reg2,
   input  logic [cpu_pkg::REG_IDX_W-1:0]        rd_reg3,
   output logic [2:0]                           rd_hazard,
   output logic [cpu_pkg::REG_IDX_W-1:0]        write_reg,
   output logic                                 write_en,
   output logic [XLEN-1:0]                      write_data,
   output logic [NREG-1:0]                      busy_mask,
   output logic                                 err_unclaimed
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: requester i commits on a rising edge where req_valid[i] and
   // req_ready[i] are both high; it holds valid/reg/data stable until then,
   // and the register file captures write_* on that same edge.

   logic [NREG-1:0]  busy_mask_q, busy_mask_d;
   logic             err_unclaimed_q, err_unclaimed_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             wb_active;
   logic [NREQ-1:0]  arb_req;
   logic [NREQ-1:0]  arb_gnt;
   logic [PTR_W-1:0] arb_idx;

   // Reset and non-writeback phases mask every request before arbitration.
   assign wb_active = (state == STATE_WB) && !reset;
   assign arb_req   = req_valid & {NREQ{wb_active}};

   rr_arbiter #(
      .N     (NREQ),
      .IDX_W (PTR_W)
   ) u_rr_arbiter (
      .req     (arb_req),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_comb begin
      req_ready  = arb_gnt;
      write_en   = |arb_gnt;
      write_reg  = '0;
      write_data = '0;
      if (write_en) begin
         write_reg  = req_reg[arb_idx];
         write_data = req_data[arb_idx];
      end
   end

   assign issue_ready = !reset && !busy_mask_q[issue_reg];

   // Hazards read the registered scoreboard only; a same-cycle commit is not bypassed.
   assign rd_hazard     = {busy_mask_q[rd_reg3], busy_mask_q[rd_reg2], busy_mask_q[rd_reg1]};
   assign busy_mask     = busy_mask_q;
   assign err_unclaimed = err_unclaimed_q;

   always_comb begin
      busy_mask_d     = busy_mask_q;
      err_unclaimed_d = err_unclaimed_q;
      rr_ptr_d        = rr_ptr_q;
      if (write_en) begin
         busy_mask_d[write_reg] = 1'b0;
         if (!busy_mask_q[write_reg]) begin
            err_unclaimed_d = 1'b1;
         end
         rr_ptr_d = PTR_W'(rr_next(int'(arb_idx), NREQ));
      end
      // A claim on a register being committed is refused by issue_ready, so the clear wins.
      if (issue_valid && issue_ready) begin
         busy_mask_d[issue_reg] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_mask_q     <= '0;
         err_unclaimed_q <= 1'b0;
         rr_ptr_q        <= '0;
      end else begin
         busy_mask_q     <= busy_mask_d;
         err_unclaimed_q <= err_unclaimed_d;
         rr_ptr_q        <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset override, single commit,
// round-robin order, non-writeback blocking, same-cycle issue/commit, errors.
module tb_regfile_write_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 64;
   localparam int NREG = 32;

   logic                       clk;
   logic                       reset;
   logic [2:0]                 state;
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0][4:0]       req_reg;
   logic [NREQ-1:0][XLEN-1:0]  req_data;
   logic                       issue_valid;
   logic [4:0]                 issue_reg;
   logic                       issue_ready;
   logic [4:0]                 rd_reg1, rd_reg2, rd_reg3;
   logic [2:0]                 rd_hazard;
   logic [4:0]                 write_reg;
   logic                       write_en;
   logic [XLEN-1:0]            write_data;
   logic [NREG-1:0]            busy_mask;
   logic                       err_unclaimed;

   int tests_run;
   int tests_failed;

   regfile_write_arbiter #(
      .NREQ (NREQ),
      .XLEN (XLEN),
      .NREG (NREG)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .state         (state),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_reg       (req_reg),
      .req_data      (req_data),
      .issue_valid   (issue_valid),
      .issue_reg     (issue_reg),
      .issue_ready   (issue_ready),
      .rd_reg1       (rd_reg1),
      .rd_reg2       (rd_reg2),
      .rd_reg3       (rd_reg3),
      .rd_hazard     (rd_hazard),
      .write_reg     (write_reg),
      .write_en      (write_en),
      .write_data    (write_data),
      .busy_mask     (busy_mask),
      .err_unclaimed (err_unclaimed)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic claim(input logic [4:0] r);
      state       = 3'b000;
      issue_valid = 1'b1;
      issue_reg   = r;
      step();
      issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      state     = 3'b100;
      req_valid = 3'b111;
      req_reg   = {5'd3, 5'd2, 5'd1};
      issue_valid = 1'b1;
      issue_reg   = 5'd4;
      #1;
      tests_run++;
      if (req_ready !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_req_ready: got %b expected 000", req_ready);
      end
      tests_run++;
      if (write_en !== 1'b0 || issue_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_override: write_en=%b issue_ready=%b expected 0 0", write_en, issue_ready);
      end
      step();
      step();
      reset       = 1'b0;
      req_valid   = 3'b000;
      issue_valid = 1'b0;
      #1;
      tests_run++;
      if (write_en !== 1'b0 || busy_mask !== '0 || err_unclaimed !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: write_en=%b busy=%h err=%b expected 0 0 0", write_en, busy_mask, err_unclaimed);
      end
      tests_run++;
      if (write_reg !== 5'd0 || write_data !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_idle_write: reg=%0d data=%h expected 0 0", write_reg, write_data);
      end
   endtask

   task automatic test_single_commit();
      issue_valid = 1'b1;
      issue_reg   = 5'd5;
      #1;
      tests_run++;
      if (issue_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL claim_r5_ready: got %b expected 1", issue_ready);
      end
      step();
      issue_valid = 1'b0;
      rd_reg1     = 5'd5;
      #1;
      tests_run++;
      if (busy_mask !== 32'h0000_0020 || rd_hazard !== 3'b001) begin
         tests_failed++;
         $display("FAIL claim_r5_busy: busy=%h hazard=%b expected 00000020 001", busy_mask, rd_hazard);
      end
      state       = 3'b100;
      req_valid   = 3'b001;
      req_reg[0]  = 5'd5;
      req_data[0] = 64'hDEAD;
      #1;
      tests_run++;
      if (req_ready !== 3'b001 || write_en !== 1'b1 || write_reg !== 5'd5 || write_data !== 64'hDEAD) begin
         tests_failed++;
         $display("FAIL alu_commit: ready=%b en=%b reg=%0d data=%h expected 001 1 5 dead",
                  req_ready, write_en, write_reg, write_data);
      end
      step();
      req_valid = 3'b000;
      #1;
      tests_run++;
      if (busy_mask !== '0 || rd_hazard !== 3'b000 || err_unclaimed !== 1'b0) begin
         tests_failed++;
         $display("FAIL alu_commit_clear: busy=%h hazard=%b err=%b expected 0 000 0", busy_mask, rd_hazard, err_unclaimed);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0]      exp_rdy [3];
      logic [4:0]      exp_reg [3];
      logic [XLEN-1:0] exp_dat [3];
      exp_rdy = '{3'b001, 3'b010, 3'b100};
      exp_reg = '{5'd1, 5'd2, 5'd31};
      exp_dat = '{64'hA1, 64'hA2, 64'h5555_0000_0000_FFF0};
      apply_reset();
      claim(5'd1);
      claim(5'd2);
      claim(5'd31);
      req_reg   = {5'd31, 5'd2, 5'd1};
      req_data  = {64'h5555_0000_0000_FFF0, 64'hA2, 64'hA1};
      req_valid = 3'b111;
      state     = 3'b100;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (req_ready !== exp_rdy[c] || write_reg !== exp_reg[c] || write_data !== exp_dat[c]) begin
            tests_failed++;
            $display("FAIL rr_cycle%0d: ready=%b reg=%0d data=%h expected %b %0d %h",
                     c, req_ready, write_reg, write_data, exp_rdy[c], exp_reg[c], exp_dat[c]);
         end
         step();
         req_valid = req_valid & ~exp_rdy[c];
      end
      #1;
      tests_run++;
      if (busy_mask !== '0 || err_unclaimed !== 1'b0) begin
         tests_failed++;
         $display("FAIL rr_busy_clear: busy=%h err=%b expected 0 0", busy_mask, err_unclaimed);
      end
      // Pointer wrapped to 0: with 0 and 1 both valid, 0 wins.
      req_valid = 3'b011;
      #1;
      tests_run++;
      if (req_ready !== 3'b001) begin
         tests_failed++;
         $display("FAIL rr_wrap: ready=%b expected 001", req_ready);
      end
      state     = 3'b000;
      req_valid = 3'b000;
   endtask

   task automatic test_non_wb();
      claim(5'd10);
      req_valid   = 3'b001;
      req_reg[0]  = 5'd10;
      req_data[0] = 64'h1234;
      state       = 3'b011;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests_run++;
         if (req_ready !== 3'b000 || write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 64'd0) begin
            tests_failed++;
            $display("FAIL non_wb_cycle%0d: ready=%b en=%b reg=%0d data=%h expected 000 0 0 0",
                     c, req_ready, write_en, write_reg, write_data);
         end
         step();
      end
      state = 3'b100;
      #1;
      tests_run++;
      if (req_ready !== 3'b001 || write_reg !== 5'd10 || write_data !== 64'h1234) begin
         tests_failed++;
         $display("FAIL non_wb_first_wb: ready=%b reg=%0d data=%h expected 001 10 1234", req_ready, write_reg, write_data);
      end
      step();
      req_valid = 3'b000;
      #1;
      tests_run++;
      if (busy_mask !== '0) begin
         tests_failed++;
         $display("FAIL non_wb_clear: busy=%h expected 0", busy_mask);
      end
   endtask

   task automatic test_same_cycle();
      // rr_ptr is 1 here, so requester 1 is used.
      claim(5'd7);
      rd_reg2     = 5'd7;
      state       = 3'b100;
      req_valid   = 3'b010;
      req_reg[1]  = 5'd7;
      req_data[1] = 64'h77;
      issue_valid = 1'b1;
      issue_reg   = 5'd7;
      #1;
      tests_run++;
      if (issue_ready !== 1'b0 || req_ready !== 3'b010 || rd_hazard[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL same_reg_issue: issue_ready=%b ready=%b hazard=%b expected 0 010 x1x", issue_ready, req_ready, rd_hazard);
      end
      step();
      req_valid   = 3'b000;
      issue_valid = 1'b0;
      #1;
      tests_run++;
      if (busy_mask !== '0 || rd_hazard !== 3'b000 || err_unclaimed !== 1'b0) begin
         tests_failed++;
         $display("FAIL same_reg_after: busy=%h hazard=%b err=%b expected 0 000 0", busy_mask, rd_hazard, err_unclaimed);
      end
      // Different registers in one cycle: commit r3 via requester 2, claim r4.
      claim(5'd3);
      state       = 3'b100;
      req_valid   = 3'b100;
      req_reg[2]  = 5'd3;
      req_data[2] = 64'h33;
      issue_valid = 1'b1;
      issue_reg   = 5'd4;
      #1;
      tests_run++;
      if (issue_ready !== 1'b1 || req_ready !== 3'b100) begin
         tests_failed++;
         $display("FAIL diff_reg_issue: issue_ready=%b ready=%b expected 1 100", issue_ready, req_ready);
      end
      step();
      req_valid   = 3'b000;
      issue_valid = 1'b0;
      #1;
      tests_run++;
      if (busy_mask !== 32'h0000_0010) begin
         tests_failed++;
         $display("FAIL diff_reg_after: busy=%h expected 00000010", busy_mask);
      end
   endtask

   task automatic test_unclaimed();
      // rr_ptr is 0; r4 is still claimed.
      state       = 3'b100;
      req_valid   = 3'b001;
      req_reg[0]  = 5'd9;
      req_data[0] = 64'h99;
      #1;
      tests_run++;
      if (write_en !== 1'b1 || write_reg !== 5'd9 || write_data !== 64'h99 || err_unclaimed !== 1'b0) begin
         tests_failed++;
         $display("FAIL unclaimed_write: en=%b reg=%0d data=%h err=%b expected 1 9 99 0",
                  write_en, write_reg, write_data, err_unclaimed);
      end
      step();
      req_valid = 3'b000;
      step();
      step();
      tests_run++;
      if (err_unclaimed !== 1'b1 || busy_mask !== 32'h0000_0010) begin
         tests_failed++;
         $display("FAIL unclaimed_sticky: err=%b busy=%h expected 1 00000010", err_unclaimed, busy_mask);
      end
      // Burst with rr_ptr=1, then reset once requester 1 has committed.
      claim(5'd12);
      state     = 3'b100;
      req_reg   = {5'd4, 5'd12, 5'd4};
      req_data  = {64'hC2, 64'hC1, 64'hC0};
      req_valid = 3'b111;
      #1;
      tests_run++;
      if (req_ready !== 3'b010 || write_reg !== 5'd12) begin
         tests_failed++;
         $display("FAIL burst_grant: ready=%b reg=%0d expected 010 12", req_ready, write_reg);
      end
      step();
      req_valid = 3'b101;
      reset     = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 3'b000 || write_en !== 1'b0 || issue_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL burst_reset_override: ready=%b en=%b issue_ready=%b expected 000 0 0", req_ready, write_en, issue_ready);
      end
      step();
      reset = 1'b0;
      #1;
      tests_run++;
      if (busy_mask !== '0 || err_unclaimed !== 1'b0) begin
         tests_failed++;
         $display("FAIL burst_reset_state: busy=%h err=%b expected 0 0", busy_mask, err_unclaimed);
      end
      // rr_ptr was 2 before reset; from 0 requester 1 wins over 2.
      req_valid = 3'b110;
      #1;
      tests_run++;
      if (req_ready !== 3'b010) begin
         tests_failed++;
         $display("FAIL burst_reset_ptr: ready=%b expected 010", req_ready);
      end
      state     = 3'b000;
      req_valid = 3'b000;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      state        = 3'b000;
      req_valid    = '0;
      req_reg      = '0;
      req_data     = '0;
      issue_valid  = 1'b0;
      issue_reg    = '0;
      rd_reg1      = '0;
      rd_reg2      = '0;
      rd_reg3      = '0;
      step();
      test_reset();
      test_single_commit();
      test_round_robin();
      test_non_wb();
      test_same_cycle();
      test_unclaimed();
      step();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
